// File: rtl/register_writeback_unit_if.sv
// Writeback bus between the execute/load stages, the register file write
// port and the register read stage.
//   slave  : the writeback unit (accepts results, drives the GPR write port
//            and the forwarding results)
//   master : the surrounding pipeline (offers results, stalls the register
//            file, issues forwarding queries)
// Signals:
//   aluValid_i/aluReg_i/aluData_i/aluReady_o      ALU result handshake
//   loadValid_i/loadReg_i/loadData_i/loadReady_o  load result handshake
//   writeStall_i                                  register file busy
//   regWriteEnable_o/regWriteAddr_o/regWriteData_o registered GPR write port
//   queryN_i, hitN_o, fwdN_o (N=1..3)             pending-write forwarding
//   queueCount_o                                  queue occupancy
interface register_writeback_unit_if #(
  parameter int dataWidth  = 64,
  parameter int regWidth   = 5,
  parameter int queueDepth = 4
);
  localparam int CNT_W = $clog2(queueDepth) + 1;

  logic                  aluValid_i;
  logic [regWidth-1:0]   aluReg_i;
  logic [dataWidth-1:0]  aluData_i;
  logic                  aluReady_o;
  logic                  loadValid_i;
  logic [regWidth-1:0]   loadReg_i;
  logic [dataWidth-1:0]  loadData_i;
  logic                  loadReady_o;
  logic                  writeStall_i;
  logic                  regWriteEnable_o;
  logic [regWidth-1:0]   regWriteAddr_o;
  logic [dataWidth-1:0]  regWriteData_o;
  logic [regWidth-1:0]   query1_i;
  logic [regWidth-1:0]   query2_i;
  logic [regWidth-1:0]   query3_i;
  logic                  hit1_o;
  logic                  hit2_o;
  logic                  hit3_o;
  logic [dataWidth-1:0]  fwd1_o;
  logic [dataWidth-1:0]  fwd2_o;
  logic [dataWidth-1:0]  fwd3_o;
  logic [CNT_W-1:0]      queueCount_o;

  modport slave (
    input  aluValid_i, aluReg_i, aluData_i,
    input  loadValid_i, loadReg_i, loadData_i,
    input  writeStall_i, query1_i, query2_i, query3_i,
    output aluReady_o, loadReady_o,
    output regWriteEnable_o, regWriteAddr_o, regWriteData_o,
    output hit1_o, hit2_o, hit3_o, fwd1_o, fwd2_o, fwd3_o,
    output queueCount_o
  );

  modport master (
    output aluValid_i, aluReg_i, aluData_i,
    output loadValid_i, loadReg_i, loadData_i,
    output writeStall_i, query1_i, query2_i, query3_i,
    input  aluReady_o, loadReady_o,
    input  regWriteEnable_o, regWriteAddr_o, regWriteData_o,
    input  hit1_o, hit2_o, hit3_o, fwd1_o, fwd2_o, fwd3_o,
    input  queueCount_o
  );
endinterface

// File: rtl/register_writeback_unit.sv
// Register writeback unit: merges ALU and load results into a circular
// queue, drains the queue into the GPR write port one entry per cycle unless
// the register file stalls, and forwards pending writes to three read-stage
// queries.
// Ports:
//   clock_i  : clock, all state changes on the rising edge
//   resset_i : synchronous active-low reset
//   bus      : register_writeback_unit_if.slave (see interface file)
module register_writeback_unit #(
  parameter int dataWidth  = 64,
  parameter int regWidth   = 5,
  parameter int queueDepth = 4
) (
  input logic                        clock_i,
  input logic                        resset_i,
  register_writeback_unit_if.slave   bus
);
  localparam int PTR_W = $clog2(queueDepth);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(queueDepth);

  // Queue storage (data only, never reset) and control state
  logic [regWidth-1:0]  ent_reg_p0  [queueDepth];
  logic [dataWidth-1:0] ent_data_p0 [queueDepth];
  logic [PTR_W-1:0]     head;
  logic [PTR_W-1:0]     tail;
  logic [CNT_W-1:0]     count;

  // Registered GPR write port
  logic                 wr_en_p1;
  logic [regWidth-1:0]  wr_addr_p1;
  logic [dataWidth-1:0] wr_data_p1;

  logic                 full;
  logic                 empty;
  logic                 push;
  logic                 pop;
  logic [regWidth-1:0]  push_reg;
  logic [dataWidth-1:0] push_data;

  // Occupancy-only readiness: a pop in the same cycle never opens a slot.
  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign bus.loadReady_o = !full;
  assign bus.aluReady_o  = !full && !bus.loadValid_i;

  // Pop decisions look at the pre-push count, so a result pushed into an
  // empty queue waits one cycle before draining.
  assign push = resset_i && !full && (bus.loadValid_i || bus.aluValid_i);
  assign pop  = resset_i && !empty && !bus.writeStall_i;

  assign push_reg  = bus.loadValid_i ? bus.loadReg_i  : bus.aluReg_i;
  assign push_data = bus.loadValid_i ? bus.loadData_i : bus.aluData_i;

  // Stage p0: queue control
  always_ff @(posedge clock_i) begin
    if (!resset_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock_i) begin
    if (push) begin
      ent_reg_p0[tail]  <= push_reg;
      ent_data_p0[tail] <= push_data;
    end
  end

  // Stage p1: GPR write port
  always_ff @(posedge clock_i) begin
    if (!resset_i) begin
      wr_en_p1   <= 1'b0;
      wr_addr_p1 <= '0;
      wr_data_p1 <= '0;
    end else if (pop) begin
      wr_en_p1   <= 1'b1;
      wr_addr_p1 <= ent_reg_p0[head];
      wr_data_p1 <= ent_data_p0[head];
    end else begin
      wr_en_p1   <= 1'b0;
    end
  end

  assign bus.regWriteEnable_o = wr_en_p1;
  assign bus.regWriteAddr_o   = wr_addr_p1;
  assign bus.regWriteData_o   = wr_data_p1;
  assign bus.queueCount_o     = count;

  // Forwarding lookup returning {hit, data}. The write port is the oldest
  // pending value; queue entries are scanned oldest to youngest so the last
  // match wins.
  function automatic logic [dataWidth:0] lookup(input logic [regWidth-1:0] q);
    logic                 hit;
    logic [dataWidth-1:0] data;
    logic [PTR_W-1:0]     idx;
    hit  = 1'b0;
    data = '0;
    if (wr_en_p1 && (wr_addr_p1 == q)) begin
      hit  = 1'b1;
      data = wr_data_p1;
    end
    for (int i = 0; i < queueDepth; i++) begin
      idx = head + PTR_W'(i);
      if ((CNT_W'(i) < count) && (ent_reg_p0[idx] == q)) begin
        hit  = 1'b1;
        data = ent_data_p0[idx];
      end
    end
    return {hit, data};
  endfunction

  logic [dataWidth:0] look1;
  logic [dataWidth:0] look2;
  logic [dataWidth:0] look3;

  always_comb begin
    look1 = lookup(bus.query1_i);
    look2 = lookup(bus.query2_i);
    look3 = lookup(bus.query3_i);
  end

  assign bus.hit1_o = look1[dataWidth];
  assign bus.fwd1_o = look1[dataWidth-1:0];
  assign bus.hit2_o = look2[dataWidth];
  assign bus.fwd2_o = look2[dataWidth-1:0];
  assign bus.hit3_o = look3[dataWidth];
  assign bus.fwd3_o = look3[dataWidth-1:0];
endmodule

// File: tb/tb_register_writeback_unit.sv
module tb_register_writeback_unit;
  localparam int DW = 64;
  localparam int RW = 5;
  localparam int QD = 4;

  logic clk;
  logic rstn;
  int   checks;
  int   errors;

  register_writeback_unit_if #(.dataWidth(DW), .regWidth(RW), .queueDepth(QD)) bus ();

  register_writeback_unit #(.dataWidth(DW), .regWidth(RW), .queueDepth(QD)) dut (
    .clock_i  (clk),
    .resset_i (rstn),
    .bus      (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Reference model: a plain queue of accepted results plus the write port
  logic [RW-1:0] mq_reg[$];
  logic [DW-1:0] mq_data[$];
  logic [RW-1:0] acc_reg[$];
  logic [DW-1:0] acc_data[$];
  logic          m_wen;
  logic [RW-1:0] m_waddr;
  logic [DW-1:0] m_wdata;

  function automatic logic [DW:0] model_fwd(input logic [RW-1:0] q);
    for (int i = mq_reg.size() - 1; i >= 0; i--)
      if (mq_reg[i] == q) return {1'b1, mq_data[i]};
    if (m_wen && m_waddr == q) return {1'b1, m_wdata};
    return '0;
  endfunction

  task automatic model_step();
    bit full, do_pop;
    if (!rstn) begin
      mq_reg.delete(); mq_data.delete(); acc_reg.delete(); acc_data.delete();
      m_wen = 0; m_waddr = '0; m_wdata = '0;
      return;
    end
    full   = (mq_reg.size() == QD);
    do_pop = (mq_reg.size() > 0) && !bus.writeStall_i;
    if (do_pop) begin
      m_wen = 1; m_waddr = mq_reg.pop_front(); m_wdata = mq_data.pop_front();
    end else begin
      m_wen = 0;
    end
    if (!full && bus.loadValid_i) begin
      mq_reg.push_back(bus.loadReg_i); mq_data.push_back(bus.loadData_i);
      acc_reg.push_back(bus.loadReg_i); acc_data.push_back(bus.loadData_i);
    end else if (!full && bus.aluValid_i) begin
      mq_reg.push_back(bus.aluReg_i); mq_data.push_back(bus.aluData_i);
      acc_reg.push_back(bus.aluReg_i); acc_data.push_back(bus.aluData_i);
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit lv, input logic [RW-1:0] lr, input logic [DW-1:0] ld,
                       input bit av, input logic [RW-1:0] ar, input logic [DW-1:0] ad,
                       input bit stall);
    bus.loadValid_i = lv; bus.loadReg_i = lr; bus.loadData_i = ld;
    bus.aluValid_i  = av; bus.aluReg_i  = ar; bus.aluData_i  = ad;
    bus.writeStall_i = stall;
  endtask

  task automatic set_q(input logic [RW-1:0] a, input logic [RW-1:0] b, input logic [RW-1:0] c);
    bus.query1_i = a; bus.query2_i = b; bus.query3_i = c;
  endtask

  task automatic test_reset();
    rstn = 0;
    drive(0, 0, 0, 0, 0, 0, 0);
    set_q(1, 2, 3);
    cycle();
    cycle();
    checks++; if (bus.queueCount_o !== 0) begin errors++; $display("FAIL reset_count got %0d exp 0", bus.queueCount_o); end
    checks++; if (bus.regWriteEnable_o !== 1'b0) begin errors++; $display("FAIL reset_wen got %b exp 0", bus.regWriteEnable_o); end
    checks++; if (bus.regWriteAddr_o !== '0 || bus.regWriteData_o !== '0) begin errors++;
      $display("FAIL reset_wport got %0d/%h exp 0/0", bus.regWriteAddr_o, bus.regWriteData_o); end
    rstn = 1;
    #1;
    checks++; if (bus.aluReady_o !== 1'b1 || bus.loadReady_o !== 1'b1) begin errors++;
      $display("FAIL reset_ready got alu %b load %b exp 1 1", bus.aluReady_o, bus.loadReady_o); end
  endtask

  task automatic test_single();
    drive(0, 0, 0, 1, 5, 64'h1234, 0);
    #1;
    checks++; if (bus.aluReady_o !== 1'b1) begin errors++; $display("FAIL single_ready got %b exp 1", bus.aluReady_o); end
    cycle();
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    checks++; if (bus.queueCount_o !== 1 || bus.regWriteEnable_o !== 1'b0) begin errors++;
      $display("FAIL single_first got count %0d wen %b exp 1 0", bus.queueCount_o, bus.regWriteEnable_o); end
    cycle();
    checks++; if (bus.regWriteEnable_o !== 1'b1 || bus.regWriteAddr_o !== 5 || bus.regWriteData_o !== 64'h1234) begin errors++;
      $display("FAIL single_write got %b/%0d/%h exp 1/5/1234", bus.regWriteEnable_o, bus.regWriteAddr_o, bus.regWriteData_o); end
    checks++; if (bus.queueCount_o !== 0) begin errors++; $display("FAIL single_count got %0d exp 0", bus.queueCount_o); end
    cycle();
    checks++; if (bus.regWriteEnable_o !== 1'b0 || bus.regWriteAddr_o !== 5) begin errors++;
      $display("FAIL single_hold got wen %b addr %0d exp 0 5", bus.regWriteEnable_o, bus.regWriteAddr_o); end
  endtask

  task automatic test_priority();
    drive(1, 3, 64'hAA, 1, 4, 64'hBB, 0);
    #1;
    checks++; if (bus.loadReady_o !== 1'b1 || bus.aluReady_o !== 1'b0) begin errors++;
      $display("FAIL prio_ready got load %b alu %b exp 1 0", bus.loadReady_o, bus.aluReady_o); end
    cycle();
    drive(0, 0, 0, 1, 4, 64'hBB, 0);
    #1;
    checks++; if (bus.aluReady_o !== 1'b1) begin errors++; $display("FAIL prio_alu_ready got %b exp 1", bus.aluReady_o); end
    cycle();
    drive(0, 0, 0, 0, 0, 0, 0);
    checks++; if (bus.regWriteEnable_o !== 1'b1 || bus.regWriteAddr_o !== 3 || bus.regWriteData_o !== 64'hAA) begin errors++;
      $display("FAIL prio_w1 got %b/%0d/%h exp 1/3/aa", bus.regWriteEnable_o, bus.regWriteAddr_o, bus.regWriteData_o); end
    cycle();
    checks++; if (bus.regWriteEnable_o !== 1'b1 || bus.regWriteAddr_o !== 4 || bus.regWriteData_o !== 64'hBB) begin errors++;
      $display("FAIL prio_w2 got %b/%0d/%h exp 1/4/bb", bus.regWriteEnable_o, bus.regWriteAddr_o, bus.regWriteData_o); end
    cycle();
  endtask

  task automatic test_stall_full();
    int k;
    bit rdy, pending;
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0, 1, RW'(10 + i), 64'h100 + 64'(i), 1);
      #1;
      checks++; if (bus.aluReady_o !== (i < 4)) begin errors++;
        $display("FAIL stall_ready%0d got %b exp %b", i, bus.aluReady_o, i < 4); end
      if (i < 4) cycle();
    end
    checks++; if (bus.queueCount_o !== 4) begin errors++; $display("FAIL stall_count got %0d exp 4", bus.queueCount_o); end
    drive(0, 0, 0, 1, 14, 64'h104, 0);
    #1;
    checks++; if (bus.aluReady_o !== 1'b0) begin errors++; $display("FAIL full_pop_noopen got %b exp 0", bus.aluReady_o); end
    k = 0;
    pending = 1;
    for (int c = 0; c < 8; c++) begin
      rdy = bus.aluReady_o;
      cycle();
      if (pending && rdy) begin pending = 0; drive(0, 0, 0, 0, 0, 0, 0); end
      if (bus.regWriteEnable_o) begin
        checks++; if (k > 4 || bus.regWriteAddr_o !== RW'(10 + k) || bus.regWriteData_o !== 64'h100 + 64'(k)) begin errors++;
          $display("FAIL stall_order%0d got %0d/%h exp %0d/%h", k, bus.regWriteAddr_o, bus.regWriteData_o, 10 + k, 64'h100 + 64'(k)); end
        k++;
      end
    end
    checks++; if (k !== 5) begin errors++; $display("FAIL stall_nwrites got %0d exp 5", k); end
  endtask

  task automatic test_forward();
    set_q(7, 9, 7);
    drive(0, 0, 0, 1, 7, 64'h1, 1);
    cycle();
    drive(0, 0, 0, 1, 7, 64'h2, 1);
    #1;
    checks++; if (bus.hit3_o !== 1'b1 || bus.fwd3_o !== 64'h1) begin errors++;
      $display("FAIL fwd_nopush got %b/%h exp 1/1", bus.hit3_o, bus.fwd3_o); end
    cycle();
    drive(0, 0, 0, 0, 0, 0, 1);
    #1;
    checks++; if (bus.hit1_o !== 1'b1 || bus.fwd1_o !== 64'h2) begin errors++;
      $display("FAIL fwd_young got %b/%h exp 1/2", bus.hit1_o, bus.fwd1_o); end
    checks++; if (bus.hit2_o !== 1'b0 || bus.fwd2_o !== 64'h0) begin errors++;
      $display("FAIL fwd_miss got %b/%h exp 0/0", bus.hit2_o, bus.fwd2_o); end
    drive(0, 0, 0, 0, 0, 0, 0);
    cycle();
    checks++; if (bus.hit1_o !== 1'b1 || bus.fwd1_o !== 64'h2) begin errors++;
      $display("FAIL fwd_queue_over_port got %b/%h exp 1/2", bus.hit1_o, bus.fwd1_o); end
    cycle();
    checks++; if (bus.hit1_o !== 1'b1 || bus.fwd1_o !== 64'h2 || bus.queueCount_o !== 0) begin errors++;
      $display("FAIL fwd_port got %b/%h cnt %0d exp 1/2 0", bus.hit1_o, bus.fwd1_o, bus.queueCount_o); end
    cycle();
    checks++; if (bus.hit1_o !== 1'b0 || bus.fwd1_o !== 64'h0) begin errors++;
      $display("FAIL fwd_gone got %b/%h exp 0/0", bus.hit1_o, bus.fwd1_o); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      drive(1, RW'(20 + i), 64'(i + 1), 0, 0, 0, 1);
      cycle();
    end
    set_q(20, 21, 22);
    drive(1, 23, 64'h55, 0, 0, 0, 0);
    rstn = 0;
    cycle();
    rstn = 1;
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    checks++; if (bus.queueCount_o !== 0 || bus.regWriteEnable_o !== 1'b0) begin errors++;
      $display("FAIL rstmid got count %0d wen %b exp 0 0", bus.queueCount_o, bus.regWriteEnable_o); end
    checks++; if ({bus.hit1_o, bus.hit2_o, bus.hit3_o} !== 3'b000) begin errors++;
      $display("FAIL rstmid_hits got %b%b%b exp 000", bus.hit1_o, bus.hit2_o, bus.hit3_o); end
    checks++; if (bus.aluReady_o !== 1'b1 || bus.loadReady_o !== 1'b1) begin errors++;
      $display("FAIL rstmid_ready got %b %b exp 1 1", bus.aluReady_o, bus.loadReady_o); end
    for (int c = 0; c < 3; c++) begin
      cycle();
      checks++; if (bus.regWriteEnable_o !== 1'b0) begin errors++; $display("FAIL rstmid_nowrite%0d got %b exp 0", c, bus.regWriteEnable_o); end
    end
  endtask

  task automatic test_random();
    logic [DW:0] e1, e2, e3;
    logic [RW-1:0] er;
    logic [DW-1:0] ed;
    for (int c = 0; c < 1000; c++) begin
      drive($urandom_range(0, 1) == 0, RW'($urandom_range(0, 3)), {$urandom(), $urandom()},
            $urandom_range(0, 1) == 0, RW'($urandom_range(0, 3)), {$urandom(), $urandom()},
            $urandom_range(0, 9) < 3);
      set_q(RW'($urandom_range(0, 3)), RW'($urandom_range(0, 3)), RW'($urandom_range(0, 3)));
      #1;
      e1 = model_fwd(bus.query1_i);
      e2 = model_fwd(bus.query2_i);
      e3 = model_fwd(bus.query3_i);
      checks++; if (bus.queueCount_o !== mq_reg.size() || bus.loadReady_o !== (mq_reg.size() != QD) ||
                    bus.aluReady_o !== (mq_reg.size() != QD && !bus.loadValid_i)) begin errors++;
        $display("FAIL rnd_ctl c%0d got cnt %0d lr %b ar %b exp cnt %0d", c, bus.queueCount_o, bus.loadReady_o, bus.aluReady_o, mq_reg.size()); end
      checks++; if ({bus.hit1_o, bus.fwd1_o} !== e1 || {bus.hit2_o, bus.fwd2_o} !== e2 || {bus.hit3_o, bus.fwd3_o} !== e3) begin errors++;
        $display("FAIL rnd_fwd c%0d got %b/%h %b/%h %b/%h exp %h %h %h", c, bus.hit1_o, bus.fwd1_o,
                 bus.hit2_o, bus.fwd2_o, bus.hit3_o, bus.fwd3_o, e1, e2, e3); end
      cycle();
      checks++; if (bus.regWriteEnable_o !== m_wen || (m_wen && (bus.regWriteAddr_o !== m_waddr || bus.regWriteData_o !== m_wdata))) begin errors++;
        $display("FAIL rnd_wport c%0d got %b/%0d/%h exp %b/%0d/%h", c, bus.regWriteEnable_o, bus.regWriteAddr_o,
                 bus.regWriteData_o, m_wen, m_waddr, m_wdata); end
      if (bus.regWriteEnable_o === 1'b1) begin
        checks++;
        if (acc_reg.size() == 0) begin errors++; $display("FAIL rnd_sb_extra c%0d got write %0d exp none", c, bus.regWriteAddr_o); end
        else begin
          er = acc_reg.pop_front(); ed = acc_data.pop_front();
          if (bus.regWriteAddr_o !== er || bus.regWriteData_o !== ed) begin errors++;
            $display("FAIL rnd_sb_order c%0d got %0d/%h exp %0d/%h", c, bus.regWriteAddr_o, bus.regWriteData_o, er, ed); end
        end
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    m_wen = 0; m_waddr = '0; m_wdata = '0;
    test_reset();
    test_single();
    test_priority();
    test_stall_full();
    test_forward();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
